// File: rtl/nn_pkg.sv
// Shared definitions for the neuron sequencer and the ALU that sits beside it.
//   ALU_*    : opcodes driven on ALUControl
//   state_t  : sequencer FSM encoding
package nn_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_MUL = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b010;
   localparam logic [2:0] ALU_NOP = 3'b011;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_MUL   = 3'd2,
      S_ACC   = 3'd3,
      S_ACT   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/neuron_mac_seq.sv
// Single-neuron multiply-accumulate sequencer. Streams N (x, w) pairs and
// drives an external combinational ALU through multiply, accumulate and
// threshold-compare steps, then reports the sum and a fire bit.
//
// Ports
//   clk, reset_n           clock, async active-low reset
//   start                  begin evaluation (IDLE only)
//   num_inputs, threshold  latched on accepted start
//   in_valid/in_ready      pair handshake; in_x, in_w pair data
//   alu_ctrl/alu_a/alu_b   to ALU ALUControl/SrcA/SrcB
//   alu_result             from ALU ALUResult (same cycle)
//   busy, done             status; done is a one-cycle pulse
//   acc_out, fire          result, held until the next accepted start
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | waiting for start, ALU idle
// FETCH | in_ready high, waiting for a pair
// MUL   | ALU multiplies x*w, product captured
// ACC   | ALU adds product into acc, count decremented
// ACT   | ALU compares acc against threshold, results latched
// DONE  | done pulse
module neuron_mac_seq
   import nn_pkg::*;
#(
   parameter int NBITS = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_inputs,
   input  logic [NBITS-1:0] threshold,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [NBITS-1:0] in_x,
   input  logic [NBITS-1:0] in_w,
   output logic [2:0]       alu_ctrl,
   output logic [NBITS-1:0] alu_a,
   output logic [NBITS-1:0] alu_b,
   input  logic [NBITS-1:0] alu_result,
   output logic             busy,
   output logic             done,
   output logic [NBITS-1:0] acc_out,
   output logic             fire
);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [NBITS-1:0] thr, x_q, w_q, prod, acc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = (num_inputs != '0) ? S_FETCH : S_ACT;
         S_FETCH: if (in_valid) state_nxt = S_MUL;
         S_MUL:   state_nxt = S_ACC;
         S_ACC:   state_nxt = (cnt == CNT_W'(1)) ? S_ACT : S_FETCH;
         S_ACT:   state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      alu_ctrl = ALU_NOP;
      alu_a    = '0;
      alu_b    = '0;
      case (state)
         S_MUL: begin
            alu_ctrl = ALU_MUL;
            alu_a    = x_q;
            alu_b    = w_q;
         end
         S_ACC: begin
            alu_ctrl = ALU_ADD;
            alu_a    = acc;
            alu_b    = prod;
         end
         S_ACT: begin
            alu_ctrl = ALU_SLT;
            alu_a    = acc;
            alu_b    = thr;
         end
         default: ;
      endcase
   end

   assign in_ready = (state == S_FETCH);
   assign busy     = (state != S_IDLE);
   assign done     = (state == S_DONE);

   // Datapath registers; all arithmetic except the count decrement is the ALU's.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= '0;
         thr     <= '0;
         x_q     <= '0;
         w_q     <= '0;
         prod    <= '0;
         acc     <= '0;
         acc_out <= '0;
         fire    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               cnt <= num_inputs;
               thr <= threshold;
               acc <= '0;
            end
            S_FETCH: if (in_valid) begin
               x_q <= in_x;
               w_q <= in_w;
            end
            S_MUL: prod <= alu_result;
            S_ACC: begin
               acc <= alu_result;
               cnt <= cnt - CNT_W'(1);
            end
            S_ACT: begin
               fire    <= alu_result[0];
               acc_out <= acc;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_mac_seq.sv
module tb_neuron_mac_seq;
   import nn_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [7:0]  num_inputs;
   logic [31:0] threshold;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_x, in_w;
   logic [2:0]  alu_ctrl;
   logic [31:0] alu_a, alu_b, alu_result;
   logic        busy, done, fire;
   logic [31:0] acc_out;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] xs [16];
   logic [31:0] ws [16];

   always #5 clk = ~clk;

   // Behavioural ALU standing in for the real execution unit.
   always_comb begin
      case (alu_ctrl)
         3'b000:  alu_result = alu_a + alu_b;
         3'b001:  alu_result = alu_a * alu_b;
         3'b010:  alu_result = (alu_a < alu_b) ? 32'd0 : 32'd1;
         default: alu_result = 32'd0;
      endcase
   end

   neuron_mac_seq #(.NBITS(32), .CNT_W(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .num_inputs (num_inputs),
      .threshold  (threshold),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_x       (in_x),
      .in_w       (in_w),
      .alu_ctrl   (alu_ctrl),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .busy       (busy),
      .done       (done),
      .acc_out    (acc_out),
      .fire       (fire)
   );

   // Drives one neuron from start to the done cycle; returns at #1 after the
   // edge where done first shows. stall = FETCH cycles held invalid per pair.
   task automatic run_neuron(input int n, input logic [31:0] thr, input int stall,
                             input bit poke, output int lat, output logic [31:0] acc_o,
                             output logic fire_o, output bit ok);
      int idx, st, cyc;
      bit xfer;
      idx = 0; st = 0; ok = 0; lat = 0; acc_o = '0; fire_o = 1'b0;
      start = 1'b1; num_inputs = n[7:0]; threshold = thr;
      @(posedge clk); #1;
      start = 1'b0; cyc = 1;
      for (int k = 0; k < 400; k++) begin
         if (done) begin
            ok = 1; lat = cyc; acc_o = acc_out; fire_o = fire;
            break;
         end
         if (poke && cyc == 2) begin
            start = 1'b1; num_inputs = 8'd5; threshold = 32'd0;
         end else start = 1'b0;
         in_x = $urandom; in_w = $urandom;
         in_valid = $urandom_range(0, 1) == 1;
         if (in_ready) begin
            in_valid = 1'b0;
            if (idx < n) begin
               if (st < stall) st++;
               else begin
                  in_valid = 1'b1; in_x = xs[idx]; in_w = ws[idx];
               end
            end
         end
         xfer = in_valid && in_ready;
         @(posedge clk);
         if (xfer) begin idx++; st = 0; end
         #1; cyc++;
      end
      start = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_reset;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || fire !== 1'b0 ||
          acc_out !== 32'd0 || alu_ctrl !== ALU_NOP || alu_a !== 32'd0 || alu_b !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b done=%b rdy=%b fire=%b acc=%h ctrl=%b a=%h b=%h, required 0 0 0 0 0 011 0 0",
                  busy, done, in_ready, fire, acc_out, alu_ctrl, alu_a, alu_b);
      end
   endtask

   task automatic test_basic;
      int lat; logic [31:0] a; logic f; bit ok;
      xs[0] = 2; ws[0] = 3; xs[1] = 4; ws[1] = 5; xs[2] = 1; ws[2] = 1;
      run_neuron(3, 32'd27, 0, 0, lat, a, f, ok);
      n_checks++;
      if (!ok || lat !== 11 || a !== 32'd27 || f !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_thr27: ok=%0d lat=%0d acc=%0d fire=%b, required 1 11 27 1", ok, lat, a, f);
      end
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || acc_out !== 32'd27 || fire !== 1'b1) begin
         n_fail++;
         $display("FAIL done_pulse_hold: done=%b busy=%b acc=%0d fire=%b, required 0 0 27 1", done, busy, acc_out, fire);
      end
      run_neuron(3, 32'd28, 0, 0, lat, a, f, ok);
      n_checks++;
      if (!ok || lat !== 11 || a !== 32'd27 || f !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_thr28: ok=%0d lat=%0d acc=%0d fire=%b, required 1 11 27 0", ok, lat, a, f);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_zero;
      int lat; logic [31:0] a; logic f; bit ok;
      run_neuron(0, 32'd0, 0, 0, lat, a, f, ok);
      n_checks++;
      if (!ok || lat !== 2 || a !== 32'd0 || f !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_thr0: ok=%0d lat=%0d acc=%0d fire=%b, required 1 2 0 1", ok, lat, a, f);
      end
      @(posedge clk); #1;
      run_neuron(0, 32'd1, 0, 0, lat, a, f, ok);
      n_checks++;
      if (!ok || lat !== 2 || a !== 32'd0 || f !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_thr1: ok=%0d lat=%0d acc=%0d fire=%b, required 1 2 0 0", ok, lat, a, f);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure;
      int lat; logic [31:0] a; logic f; bit ok;
      xs[0] = 3; ws[0] = 3; xs[1] = 2; ws[1] = 2;
      run_neuron(2, 32'd13, 4, 0, lat, a, f, ok);
      n_checks++;
      if (!ok || lat !== 16 || a !== 32'd13 || f !== 1'b1) begin
         n_fail++;
         $display("FAIL backpressure: ok=%0d lat=%0d acc=%0d fire=%b, required 1 16 13 1", ok, lat, a, f);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_wrap;
      int lat; logic [31:0] a; logic f; bit ok;
      xs[0] = 32'h8000_0000; ws[0] = 2; xs[1] = 32'hFFFF_FFFF; ws[1] = 1;
      run_neuron(2, 32'd5, 0, 0, lat, a, f, ok);
      n_checks++;
      if (!ok || lat !== 8 || a !== 32'hFFFF_FFFF || f !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap: ok=%0d lat=%0d acc=%h fire=%b, required 1 8 ffffffff 1", ok, lat, a, f);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_midreset;
      int adds, lat; logic [31:0] a; logic f; bit ok, seen_done, hit;
      for (int i = 0; i < 4; i++) begin xs[i] = i + 3; ws[i] = 9; end
      start = 1'b1; num_inputs = 8'd4; threshold = 32'd1;
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b1; in_x = 32'd5; in_w = 32'd5;
      adds = 0; hit = 0;
      for (int k = 0; k < 50 && !hit; k++) begin
         if (alu_ctrl == ALU_ADD) adds++;
         if (adds == 2) hit = 1;
         else begin @(posedge clk); #1; end
      end
      n_checks++;
      if (!hit) begin
         n_fail++;
         $display("FAIL midreset_reach_acc: second ACC seen=%0d, required 1", hit);
      end
      reset_n = 1'b0; in_valid = 1'b0;
      #2;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || fire !== 1'b0 ||
          acc_out !== 32'd0 || alu_ctrl !== ALU_NOP || alu_a !== 32'd0 || alu_b !== 32'd0) begin
         n_fail++;
         $display("FAIL midreset_outputs: busy=%b done=%b rdy=%b fire=%b acc=%h ctrl=%b a=%h b=%h, required 0 0 0 0 0 011 0 0",
                  busy, done, in_ready, fire, acc_out, alu_ctrl, alu_a, alu_b);
      end
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;
      seen_done = 0;
      for (int k = 0; k < 14; k++) begin
         @(posedge clk); #1;
         if (done || busy) seen_done = 1;
      end
      n_checks++;
      if (seen_done) begin
         n_fail++;
         $display("FAIL midreset_no_done: activity after reset=%0d, required 0", seen_done);
      end
      xs[0] = 7; ws[0] = 6;
      run_neuron(1, 32'd40, 0, 1, lat, a, f, ok);
      n_checks++;
      if (!ok || lat !== 5 || a !== 32'd42 || f !== 1'b1) begin
         n_fail++;
         $display("FAIL after_reset_poke: ok=%0d lat=%0d acc=%0d fire=%b, required 1 5 42 1", ok, lat, a, f);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      int lat; logic [31:0] a; logic f; bit ok;
      xs[0] = 10; ws[0] = 10;
      run_neuron(1, 32'd200, 0, 0, lat, a, f, ok);
      n_checks++;
      if (!ok || lat !== 5 || a !== 32'd100 || f !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_first: ok=%0d lat=%0d acc=%0d fire=%b, required 1 5 100 0", ok, lat, a, f);
      end
      start = 1'b1; num_inputs = 8'd0; threshold = 32'd0;
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_start_in_done: busy=%b done=%b, required 0 0", busy, done);
      end
      @(posedge clk); #1;
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || alu_ctrl !== ALU_SLT || acc_out !== 32'd100) begin
         n_fail++;
         $display("FAIL b2b_accept: busy=%b ctrl=%b acc=%0d, required 1 010 100", busy, alu_ctrl, acc_out);
      end
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b1 || acc_out !== 32'd0 || fire !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_second: done=%b acc=%0d fire=%b, required 1 0 1", done, acc_out, fire);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random;
      int n, stall, lat, exp_lat; logic [31:0] a, exp_acc, thr; logic f, exp_fire; bit ok;
      for (int t = 0; t < 10; t++) begin
         n = $urandom_range(0, 6);
         stall = $urandom_range(0, 2);
         exp_acc = 32'd0;
         for (int i = 0; i < n; i++) begin
            if (t % 2 == 0) begin
               xs[i] = $urandom_range(0, 200); ws[i] = $urandom_range(0, 200);
            end else begin
               xs[i] = $urandom; ws[i] = $urandom;
            end
            exp_acc = exp_acc + xs[i] * ws[i];
         end
         case (t % 3)
            0: thr = exp_acc;
            1: thr = exp_acc + 32'd1;
            default: thr = $urandom;
         endcase
         exp_fire = (exp_acc >= thr);
         exp_lat = 3 * n + 2 + n * stall;
         run_neuron(n, thr, stall, 0, lat, a, f, ok);
         n_checks++;
         if (!ok || lat !== exp_lat || a !== exp_acc || f !== exp_fire) begin
            n_fail++;
            $display("FAIL random_%0d: ok=%0d lat=%0d acc=%h fire=%b, required 1 %0d %h %b",
                     t, ok, lat, a, f, exp_lat, exp_acc, exp_fire);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; num_inputs = '0; threshold = '0;
      in_valid = 1'b0; in_x = '0; in_w = '0;
      repeat (3) @(posedge clk);
      #1;
      test_reset;
      reset_n = 1'b1;
      @(posedge clk); #1;
      test_reset;
      test_basic;
      test_zero;
      test_backpressure;
      test_wrap;
      test_midreset;
      test_back_to_back;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/neuron_mac_seq.md
# neuron_mac_seq

Sequencer stage directly upstream of the ALU execution unit. Computes one neuron: streams in N (input, weight) pairs and drives the ALU's control and operand ports through multiply, accumulate and threshold-compare steps. Reads the ALU result back combinationally and registers it. Emits the accumulated sum and a fire bit for the neuron.

## Interface
- NBITS, 32, datapath width; must match the ALU nBits.
- CNT_W, 8, width of the input-count field.

- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin neuron evaluation; sampled only in IDLE.
- num_inputs  in  CNT_W  number of pairs N; latched on accepted start.
- threshold  in  NBITS  firing threshold; latched on accepted start.
- in_valid  in  1  in_x/in_w valid.
- in_ready  out  1  sequencer accepts a pair this cycle.
- in_x  in  NBITS  neuron input.
- in_w  in  NBITS  weight.
- alu_ctrl  out  3  to ALU control: 000 add, 001 mul, 010 slt, 011 idle.
- alu_a  out  NBITS  to ALU SrcA.
- alu_b  out  NBITS  to ALU SrcB.
- alu_result  in  NBITS  from the ALU result, combinational, same cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when acc_out and fire are valid.
- acc_out  out  NBITS  final accumulated sum; held until the next accepted start.
- fire  out  1  1 iff acc ≥ threshold (unsigned); held until the next accepted start.

## Operation
- FSM states: IDLE, FETCH, MUL, ACC, ACT, DONE.
- **IDLE**
  - alu_ctrl=011, alu_a=alu_b=0.
  - On start: latch num_inputs into cnt and latch threshold; clear acc.
  - If num_inputs≠0, go to FETCH; if num_inputs==0, go to ACT.
- **FETCH**
  - in_ready=1.
  - On in_valid: latch x and w, go to MUL. Otherwise stay.
- **MUL**
  - alu_ctrl=001, alu_a=x, alu_b=w.
  - prod ← alu_result, i.e. the lower NBITS bits of the product. Go to ACC.
- **ACC**
  - alu_ctrl=000, alu_a=acc, alu_b=prod.
  - acc ← alu_result, with modulo-2^NBITS wrap and no saturation. cnt ← cnt−1.
  - If cnt==1, go to ACT; otherwise go to FETCH.
- **ACT**
  - alu_ctrl=010, alu_a=acc, alu_b=threshold.
  - The ALU returns 0 when acc<threshold, 1 otherwise.
  - fire ← alu_result[0]; acc_out ← acc. Go to DONE.
- **DONE**
  - done=1. Go to IDLE.
- start is ignored outside IDLE. in_ready is low outside FETCH, so no pair is consumed in any other state.
- Every arithmetic operation goes through the ALU. The block contains no adder or multiplier of its own, except the cnt decrement.

## Timing
- Reset values: state=IDLE, in_ready=0, busy=0, done=0, fire=0, acc_out=0, alu_ctrl=011, alu_a=alu_b=0. All internal registers are cleared.
- Reset asserted mid-operation: FSM returns to IDLE immediately. Any partial accumulation is discarded and no done pulse is issued.
- All outputs are decoded from registered state only; there is no combinational path from inputs to outputs.
- Per-pair cost is 3 cycles (FETCH, MUL, ACC) when in_valid is already high on FETCH entry, plus one extra cycle per cycle in_valid is low.
- Latency from accepted start to done:
  - 3N+2 cycles with no stalls.
  - 2 cycles for N=0.
- A pair transfers on the clk edge where in_valid && in_ready are both high.
- done goes high exactly one cycle after ACT. acc_out and fire are stable from the done cycle until the next accepted start.
- A start in the DONE cycle is ignored. The earliest new start is accepted in the cycle after done.

## Structure
- Shared package nn_pkg holds:
  - ALU opcode constants ALU_ADD=3'b000, ALU_MUL=3'b001, ALU_SLT=3'b010, ALU_NOP=3'b011;
  - the FSM state encoding.
- Single module with no sub-modules. The ALU is instantiated beside this block at top level and in the bench, with alu_* wired to ALUControl, SrcA, SrcB and ALUResult.

## Test plan
- N=3, pairs (2,3), (4,5), (1,1), threshold=27, in_valid held high -> done at cycle 11 after start, acc_out=27, fire=1.
- Same pairs with threshold=28 -> acc_out=27, fire=0.
- N=0, threshold=0 -> done 2 cycles after start, acc_out=0, fire=1. Repeat with threshold=1 -> fire=0.
- Backpressure: N=2, pairs (3,3), (2,2), in_valid low for 4 cycles before each pair -> no pair transfers while in_valid is low; acc_out=13; latency 8+8=16 cycles.
- Wrap: N=2, pairs (32'h8000_0000, 2) and (32'hFFFF_FFFF, 1) -> product 0 (truncated), acc_out=32'hFFFF_FFFF, fire=1 for threshold=5.
- Reset_n pulsed low during the second ACC of an N=4 run -> all outputs at reset values and no done pulse. A following start with N=1, pair (7,6), threshold=40 -> acc_out=42, fire=1. A start pulsed while busy -> ignored.
